// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin arbiter that lets NUM_REQ byte streams share
// one uart_tx. A grant is held for a whole packet (up to req_last) and is
// revoked if the holder stays idle for LOCK_TIMEOUT cycles.
//
// Ports:
//   clk_i           clock, rising edge
//   rst_ni          synchronous active-low reset
//   req_valid_i     per-requester byte valid
//   req_data_i      per-requester byte, requester i on [8i+7:8i]
//   req_last_i      per-requester end-of-packet marker
//   req_ready_o     per-requester accept (decoded from registered state)
//   out_data_o      byte to uart_tx
//   out_valid_o     byte valid to uart_tx
//   out_ready_i     uart_tx ready
//   grant_active_o  a requester holds the grant (LOCK or SEND)
//   grant_id_o      current or most recent grant holder
//   timeout_pulse_o one-cycle pulse when a grant is revoked by timeout
module uart_tx_arbiter #(
    parameter  int NUM_REQ      = 4,
    parameter  int LOCK_TIMEOUT = 1000,
    localparam int ID_W         = $clog2(NUM_REQ)
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [NUM_REQ-1:0]   req_valid_i,
    input  logic [8*NUM_REQ-1:0] req_data_i,
    input  logic [NUM_REQ-1:0]   req_last_i,
    output logic [NUM_REQ-1:0]   req_ready_o,
    output logic [7:0]           out_data_o,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic                 grant_active_o,
    output logic [ID_W-1:0]      grant_id_o,
    output logic                 timeout_pulse_o
);

    localparam int CNT_W = $clog2(LOCK_TIMEOUT);
    localparam logic [CNT_W-1:0] TMO_MAX = CNT_W'(LOCK_TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE,
        LOCK,
        SEND
    } state_e;

    state_e            state_q;
    logic [ID_W-1:0]   grant_id_q;
    logic [ID_W-1:0]   last_id_q;
    logic [7:0]        out_data_q;
    logic              out_valid_q;
    logic              last_flag_q;
    logic              grant_active_q;
    logic              timeout_pulse_q;
    logic [CNT_W-1:0]  tcnt_q;

    logic [ID_W-1:0]   pick_id;
    logic              pick_vld;
    logic              sel_valid;
    logic              sel_last;
    logic [7:0]        sel_data;

    // Round-robin search starting just after the last holder, with wrap.
    always_comb begin : rr_search
        logic [ID_W-1:0] cand;
        cand     = '0;
        pick_id  = last_id_q;
        pick_vld = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = ID_W'((int'(last_id_q) + k) % NUM_REQ);
            if (!pick_vld && req_valid_i[cand]) begin
                pick_id  = cand;
                pick_vld = 1'b1;
            end
        end
    end

    // Signals of the current grant holder.
    always_comb begin : holder_mux
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        sel_data  = 8'h00;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_id_q == ID_W'(i)) begin
                sel_valid = req_valid_i[i];
                sel_last  = req_last_i[i];
                sel_data  = req_data_i[8*i +: 8];
            end
        end
    end

    // Ready depends on registered state only, never on req_valid.
    always_comb begin : ready_decode
        req_ready_o = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_ready_o[i] = (state_q == LOCK) &&
                             (grant_id_q == ID_W'(i));
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q         <= IDLE;
            grant_id_q      <= '0;
            last_id_q       <= ID_W'(NUM_REQ - 1);
            out_data_q      <= 8'h00;
            out_valid_q     <= 1'b0;
            last_flag_q     <= 1'b0;
            grant_active_q  <= 1'b0;
            timeout_pulse_q <= 1'b0;
            tcnt_q          <= '0;
        end else begin
            timeout_pulse_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (pick_vld) begin
                        grant_id_q     <= pick_id;
                        grant_active_q <= 1'b1;
                        tcnt_q         <= '0;
                        state_q        <= LOCK;
                    end
                end
                LOCK: begin
                    // A byte arriving in the would-be timeout cycle wins.
                    if (sel_valid) begin
                        out_data_q  <= sel_data;
                        last_flag_q <= sel_last;
                        out_valid_q <= 1'b1;
                        tcnt_q      <= '0;
                        state_q     <= SEND;
                    end else if (tcnt_q == TMO_MAX) begin
                        tcnt_q          <= '0;
                        last_id_q       <= grant_id_q;
                        timeout_pulse_q <= 1'b1;
                        grant_active_q  <= 1'b0;
                        state_q         <= IDLE;
                    end else begin
                        tcnt_q <= tcnt_q + 1'b1;
                    end
                end
                SEND: begin
                    if (out_ready_i) begin
                        out_valid_q <= 1'b0;
                        if (last_flag_q) begin
                            last_id_q      <= grant_id_q;
                            grant_active_q <= 1'b0;
                            state_q        <= IDLE;
                        end else begin
                            state_q <= LOCK;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign out_data_o      = out_data_q;
    assign out_valid_o     = out_valid_q;
    assign grant_active_o  = grant_active_q;
    assign grant_id_o      = grant_id_q;
    assign timeout_pulse_o = timeout_pulse_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed scenarios for uart_tx_arbiter
// (NUM_REQ=4, LOCK_TIMEOUT=8).
module tb_uart_tx_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_last;
    logic [3:0]  req_ready;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic        grant_active;
    logic [1:0]  grant_id;
    logic        timeout_pulse;

    int vec  = 0;
    int errs = 0;

    logic [7:0] pd [4][16];
    logic       pl [4][16];
    int         pn [4];
    int         pp [4];

    logic [7:0] log_d [32];
    logic [1:0] log_g [32];
    int         log_n;
    int         cyc;
    int         gap_err;
    bit         prev_xfer;
    int         tp_cnt;
    int         tp_cyc;

    always #5 clk = ~clk;

    uart_tx_arbiter #(
        .NUM_REQ      (4),
        .LOCK_TIMEOUT (8)
    ) dut (
        .clk_i           (clk),
        .rst_ni          (rst_n),
        .req_valid_i     (req_valid),
        .req_data_i      (req_data),
        .req_last_i      (req_last),
        .req_ready_o     (req_ready),
        .out_data_o      (out_data),
        .out_valid_o     (out_valid),
        .out_ready_i     (out_ready),
        .grant_active_o  (grant_active),
        .grant_id_o      (grant_id),
        .timeout_pulse_o (timeout_pulse)
    );

    task automatic drive();
        for (int i = 0; i < 4; i++) begin
            if (pp[i] < pn[i]) begin
                req_valid[i]       = 1'b1;
                req_data[8*i +: 8] = pd[i][pp[i]];
                req_last[i]        = pl[i][pp[i]];
            end else begin
                req_valid[i]       = 1'b0;
                req_data[8*i +: 8] = 8'h00;
                req_last[i]        = 1'b0;
            end
        end
    endtask

    task automatic push(input int r, input logic [7:0] d, input logic l);
        pd[r][pn[r]] = d;
        pl[r][pn[r]] = l;
        pn[r]++;
    endtask

    task automatic clear_all();
        for (int i = 0; i < 4; i++) begin
            pn[i] = 0;
            pp[i] = 0;
        end
        log_n     = 0;
        gap_err   = 0;
        prev_xfer = 1'b0;
        tp_cnt    = 0;
        tp_cyc    = -1;
        drive();
    endtask

    // One clock: note handshakes of this cycle, then advance past the edge.
    task automatic step();
        logic [3:0] xf;
        bit         ox;
        xf = req_valid & req_ready;
        ox = out_valid && out_ready;
        if (prev_xfer && out_valid) gap_err++;
        if (ox && log_n < 32) begin
            log_d[log_n] = out_data;
            log_g[log_n] = grant_id;
            log_n++;
        end
        prev_xfer = ox;
        @(posedge clk);
        #1;
        cyc++;
        for (int i = 0; i < 4; i++) if (xf[i]) pp[i]++;
        drive();
        if (timeout_pulse) begin
            tp_cnt++;
            tp_cyc = cyc;
        end
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        out_ready = 1'b1;
        clear_all();
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        vec++;
        if (out_valid !== 1'b0) begin
            errs++;
            $display("FAIL rst out_valid: got %b want 0", out_valid);
        end
        vec++;
        if (out_data !== 8'h00) begin
            errs++;
            $display("FAIL rst out_data: got %h want 00", out_data);
        end
        vec++;
        if (grant_active !== 1'b0) begin
            errs++;
            $display("FAIL rst grant_active: got %b want 0", grant_active);
        end
        vec++;
        if (grant_id !== 2'd0) begin
            errs++;
            $display("FAIL rst grant_id: got %0d want 0", grant_id);
        end
        vec++;
        if (timeout_pulse !== 1'b0) begin
            errs++;
            $display("FAIL rst timeout_pulse: got %b want 0", timeout_pulse);
        end
        vec++;
        if (req_ready !== 4'b0000) begin
            errs++;
            $display("FAIL rst req_ready: got %b want 0000", req_ready);
        end
    endtask

    task automatic test_single();
        do_reset();
        push(0, 8'h55, 1'b0);
        push(0, 8'hA3, 1'b1);
        drive();
        vec++;
        if (req_ready !== 4'b0000) begin
            errs++;
            $display("FAIL single c0 ready: got %b want 0000", req_ready);
        end
        step();
        vec++;
        if (req_ready !== 4'b0001 || out_valid !== 1'b0) begin
            errs++;
            $display("FAIL single c1 ready/valid: got %b/%b want 0001/0",
                     req_ready, out_valid);
        end
        vec++;
        if (grant_active !== 1'b1 || grant_id !== 2'd0) begin
            errs++;
            $display("FAIL single c1 grant: got %b/%0d want 1/0",
                     grant_active, grant_id);
        end
        step();
        vec++;
        if (out_valid !== 1'b1 || out_data !== 8'h55) begin
            errs++;
            $display("FAIL single c2 out: got %b/%h want 1/55",
                     out_valid, out_data);
        end
        for (int k = 0; k < 20 && log_n < 2; k++) step();
        vec++;
        if (log_n !== 2) begin
            errs++;
            $display("FAIL single count: got %0d want 2", log_n);
        end else begin
            vec++;
            if (log_d[0] !== 8'h55 || log_d[1] !== 8'hA3) begin
                errs++;
                $display("FAIL single bytes: got %h %h want 55 a3",
                         log_d[0], log_d[1]);
            end
        end
        vec++;
        if (grant_active !== 1'b0 || out_valid !== 1'b0) begin
            errs++;
            $display("FAIL single idle: got %b/%b want 0/0",
                     grant_active, out_valid);
        end
        vec++;
        if (gap_err !== 0) begin
            errs++;
            $display("FAIL single gap: got %0d want 0", gap_err);
        end
    endtask

    task automatic test_round_robin();
        logic [7:0] e;
        do_reset();
        for (int i = 0; i < 4; i++) push(i, 8'(16 + i), 1'b1);
        drive();
        for (int k = 0; k < 60 && log_n < 4; k++) step();
        vec++;
        if (log_n !== 4) begin
            errs++;
            $display("FAIL rr count: got %0d want 4", log_n);
        end
        for (int i = 0; i < 4 && i < log_n; i++) begin
            e = 8'(16 + i);
            vec++;
            if (log_d[i] !== e || log_g[i] !== 2'(i)) begin
                errs++;
                $display("FAIL rr slot %0d: got %h/g%0d want %h/g%0d",
                         i, log_d[i], log_g[i], e, i);
            end
        end
        vec++;
        if (gap_err !== 0) begin
            errs++;
            $display("FAIL rr gap: got %0d want 0", gap_err);
        end
    endtask

    task automatic test_packet_lock();
        logic [7:0] ed [4];
        logic [1:0] eg [4];
        ed[0] = 8'h01; ed[1] = 8'h02; ed[2] = 8'h03; ed[3] = 8'hFF;
        eg[0] = 2'd1;  eg[1] = 2'd1;  eg[2] = 2'd1;  eg[3] = 2'd2;
        do_reset();
        push(1, 8'h01, 1'b0);
        push(1, 8'h02, 1'b0);
        push(1, 8'h03, 1'b1);
        push(2, 8'hFF, 1'b1);
        drive();
        for (int k = 0; k < 60 && log_n < 4; k++) step();
        vec++;
        if (log_n !== 4) begin
            errs++;
            $display("FAIL lock count: got %0d want 4", log_n);
        end
        for (int i = 0; i < 4 && i < log_n; i++) begin
            vec++;
            if (log_d[i] !== ed[i] || log_g[i] !== eg[i]) begin
                errs++;
                $display("FAIL lock slot %0d: got %h/g%0d want %h/g%0d",
                         i, log_d[i], log_g[i], ed[i], eg[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        out_ready = 1'b0;
        push(3, 8'h5A, 1'b1);
        drive();
        for (int k = 0; k < 10 && !out_valid; k++) step();
        for (int k = 0; k < 20; k++) begin
            vec++;
            if (out_valid !== 1'b1 || out_data !== 8'h5A) begin
                errs++;
                $display("FAIL bp hold c%0d: got %b/%h want 1/5a",
                         k, out_valid, out_data);
            end
            step();
        end
        out_ready = 1'b1;
        for (int k = 0; k < 6; k++) step();
        vec++;
        if (log_n !== 1 || log_d[0] !== 8'h5A) begin
            errs++;
            $display("FAIL bp xfer: got n=%0d %h want n=1 5a",
                     log_n, log_d[0]);
        end
        vec++;
        if (grant_active !== 1'b0) begin
            errs++;
            $display("FAIL bp idle: got %b want 0", grant_active);
        end
    endtask

    task automatic test_timeout();
        int d;
        d = -1;
        do_reset();
        push(2, 8'h21, 1'b0);
        push(3, 8'h33, 1'b1);
        drive();
        for (int k = 0; k < 60 && tp_cnt == 0; k++) begin
            if (d < 0 && req_ready[2] && !req_valid[2]) d = cyc;
            step();
        end
        vec++;
        if (d < 0 || tp_cnt == 0 || tp_cyc - d !== 8) begin
            errs++;
            $display("FAIL tmo delay: got %0d want 8", tp_cyc - d);
        end
        for (int k = 0; k < 30 && log_n < 2; k++) step();
        step();
        step();
        vec++;
        if (tp_cnt !== 1) begin
            errs++;
            $display("FAIL tmo pulses: got %0d want 1", tp_cnt);
        end
        vec++;
        if (log_n !== 2 || log_d[0] !== 8'h21 || log_g[0] !== 2'd2 ||
            log_d[1] !== 8'h33 || log_g[1] !== 2'd3) begin
            errs++;
            $display("FAIL tmo seq: got n=%0d %h/g%0d %h/g%0d want 21/g2 33/g3",
                     log_n, log_d[0], log_g[0], log_d[1], log_g[1]);
        end
    endtask

    task automatic test_timeout_race();
        int d;
        d = -1;
        do_reset();
        push(1, 8'h41, 1'b0);
        drive();
        for (int k = 0; k < 20 && d < 0; k++) begin
            if (req_ready[1] && !req_valid[1]) d = cyc;
            else step();
        end
        for (int k = 0; k < 7; k++) step();
        push(1, 8'h42, 1'b1);
        drive();
        for (int k = 0; k < 30 && log_n < 2; k++) step();
        for (int k = 0; k < 12; k++) step();
        vec++;
        if (tp_cnt !== 0) begin
            errs++;
            $display("FAIL race pulses: got %0d want 0", tp_cnt);
        end
        vec++;
        if (log_n !== 2 || log_d[1] !== 8'h42) begin
            errs++;
            $display("FAIL race seq: got n=%0d %h want n=2 42",
                     log_n, log_d[1]);
        end
    endtask

    task automatic test_reset_mid_send();
        do_reset();
        push(0, 8'h60, 1'b1);
        push(2, 8'h77, 1'b1);
        drive();
        for (int k = 0; k < 20 && log_n < 1; k++) step();
        out_ready = 1'b0;
        for (int k = 0; k < 20 && !out_valid; k++) step();
        vec++;
        if (out_valid !== 1'b1 || out_data !== 8'h77) begin
            errs++;
            $display("FAIL rms send: got %b/%h want 1/77", out_valid, out_data);
        end
        push(0, 8'h70, 1'b1);
        push(1, 8'h71, 1'b1);
        drive();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        vec++;
        if (out_valid !== 1'b0 || grant_active !== 1'b0) begin
            errs++;
            $display("FAIL rms clear: got %b/%b want 0/0",
                     out_valid, grant_active);
        end
        vec++;
        if (req_ready !== 4'b0000 || grant_id !== 2'd0) begin
            errs++;
            $display("FAIL rms ready/id: got %b/%0d want 0000/0",
                     req_ready, grant_id);
        end
        out_ready = 1'b1;
        for (int k = 0; k < 40 && log_n < 3; k++) step();
        vec++;
        if (log_n !== 3 || log_d[1] !== 8'h70 || log_g[1] !== 2'd0 ||
            log_d[2] !== 8'h71 || log_g[2] !== 2'd1) begin
            errs++;
            $display("FAIL rms order: got n=%0d %h/g%0d %h/g%0d want 70/g0 71/g1",
                     log_n, log_d[1], log_g[1], log_d[2], log_g[2]);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        cyc       = 0;
        rst_n     = 1'b0;
        out_ready = 1'b1;
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        test_reset();
        test_single();
        test_round_robin();
        test_packet_lock();
        test_backpressure();
        test_timeout();
        test_timeout_race();
        test_reset_mid_send();
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter: NUM_REQ, 4, number of requesters sharing one uart_tx (range 2..8).
REQ-002 Parameter: LOCK_TIMEOUT, 1000, consecutive idle-requester cycles in LOCK before the grant is revoked (must be >= 2).
REQ-003 Localparam: ID_W = clog2(NUM_REQ).
REQ-004 clk  input  1  single clock; all logic on the rising edge.
REQ-005 rst_n  input  1  reset, synchronous, active-low.
REQ-006 req_valid  input  NUM_REQ  per-requester byte valid.
REQ-007 req_data  input  8*NUM_REQ  per-requester byte; requester i uses bits [8i+7:8i].
REQ-008 req_last  input  NUM_REQ  marks the final byte of a requester's packet.
REQ-009 req_ready  output  NUM_REQ  per-requester accept; a byte transfers when req_valid[i] and req_ready[i] are both high.
REQ-010 out_data  output  8  byte to uart_tx tx_data.
REQ-011 out_valid  output  1  to uart_tx tx_data_valid.
REQ-012 out_ready  input  1  from uart_tx tx_data_ready; a downstream transfer occurs when out_valid and out_ready are both high.
REQ-013 grant_active  output  1  high while a requester holds the grant (LOCK or SEND).
REQ-014 grant_id  output  ID_W  index of the current or most recent grant holder.
REQ-015 timeout_pulse  output  1  one-cycle pulse when a grant is revoked by timeout.

Function
REQ-016 FSM states: IDLE, LOCK, SEND; all outputs except req_ready are registered.
REQ-017 IDLE: if any req_valid is high, the block selects the first requester with req_valid high, searching from index (last_id+1) mod NUM_REQ upward with wrap; it loads grant_id and goes to LOCK on the next edge.
REQ-018 IDLE with no req_valid: the block stays in IDLE with grant_active=0.
REQ-019 req_ready[i] = (state==LOCK) and (grant_id==i); the decode uses registered state only and does not depend on req_valid.
REQ-020 LOCK with req_valid[grant_id]=1: the block captures the byte into out_data and req_last[grant_id] into last_flag, sets out_valid=1, and goes to SEND.
REQ-021 SEND: out_valid and out_data are held stable until out_ready=1; on that edge out_valid<=0.
REQ-022 SEND exit: if last_flag=1, go to IDLE and set last_id<=grant_id; otherwise return to LOCK with the same grant.
REQ-023 Downstream traffic: at most one byte is outstanding, and out_valid is low for at least one cycle between consecutive bytes.
REQ-024 Latency: req_valid rising in IDLE at cycle 0 gives req_ready high in cycle 1 and out_valid high in cycle 2.
REQ-025 Timeout counter: counts cycles in LOCK with req_valid[grant_id]=0, and clears on req_valid[grant_id]=1 or on leaving LOCK.
REQ-026 Timeout: when the counter equals LOCK_TIMEOUT-1 and req_valid[grant_id] is still 0, the block goes to IDLE, sets last_id<=grant_id, and asserts timeout_pulse for exactly one cycle.
REQ-027 Simultaneous event: if req_valid[grant_id] rises in the would-be timeout cycle, the transfer wins and no timeout occurs.
REQ-028 Other requesters' req_valid is ignored while a grant is held; there is no preemption.
REQ-029 Requester obligation: req_data and req_last must be held while req_valid is high and ready is low; the block does not check this.
REQ-030 Fairness: a requester holding continuous traffic regains the grant only after every other pending requester has completed one packet or timed out.

Reset
REQ-031 rst_n=0 sampled at a clock edge sets the following values at that edge, including mid-packet or mid-SEND: state=IDLE, out_valid=0, out_data=0, grant_active=0, grant_id=0, last_id=NUM_REQ-1 (requester 0 has first priority), timeout counter=0, timeout_pulse=0, req_ready=0.
REQ-032 A byte held in SEND when reset is applied is discarded; the downstream uart_tx is reset by its own reset.

Verification
REQ-033 Single requester: req0 sends 0x55 then 0xA3 (last), out_ready tied 1 -> out_data 0x55 then 0xA3, each out_valid one cycle, then IDLE with grant_active=0.
REQ-034 Round-robin: after reset all four requesters assert single-byte packets (last=1) with values 0x10, 0x11, 0x12, 0x13 -> grant order 0,1,2,3; out_data sequence 0x10, 0x11, 0x12, 0x13.
REQ-035 Packet lock: req1 sends a 3-byte packet 0x01, 0x02, 0x03 while req2 stays valid with 0xFF -> 0xFF appears only after 0x03.
REQ-036 Backpressure: out_ready held 0 for 20 cycles in SEND -> out_data and out_valid are stable for all 20 cycles; exactly one transfer occurs after out_ready=1.
REQ-037 Timeout: LOCK_TIMEOUT=8, req2 drops valid mid-packet -> timeout_pulse high exactly 8 cycles after the drop; grant passes to req3 if it is pending.
REQ-038 Reset mid-SEND: rst_n=0 for one cycle while out_valid=1 -> next cycle out_valid=0, grant_active=0, and requester 0 has first priority.
